// File: rtl/he_pkg.sv
// Shared constants and types for the histogram-equalization pipeline.
// The frame geometry defaults are also used by the equalizer stage.
package he_pkg;

  // Default frame geometry (raster order, pixels x lines)
  localparam int DEFAULT_IMAGE_WIDTH  = 32'sd660;
  localparam int DEFAULT_IMAGE_HEIGHT = 32'sd440;

  // Pixel component / luma width
  localparam int PIX_W = 32'sd8;

  // BT.601-style luma weights; they sum to 256 so the result never exceeds 255
  localparam int LUMA_COEF_R = 32'sd77;
  localparam int LUMA_COEF_G = 32'sd150;
  localparam int LUMA_COEF_B = 32'sd29;
  localparam int LUMA_ROUND  = 32'sd128;

  // Product widths: 77*255, 150*255 and 29*255 fit in 15, 16 and 13 bits
  localparam int PROD_R_W   = 32'sd15;
  localparam int PROD_G_W   = 32'sd16;
  localparam int PROD_B_W   = 32'sd13;
  localparam int LUMA_SUM_W = 32'sd16;

  // Frame position markers that travel alongside each pixel
  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } marker_t;

endpackage

// File: rtl/rgb2gray_stream.sv
// RGB888 to 8-bit luma converter with valid/ready flow control.
// Two registered stages (products, then rounded sum) stall together;
// each output pixel carries start-of-frame / end-of-line / end-of-frame tags.
module rgb2gray_stream
  import he_pkg::*;
#(
  parameter int IMAGE_WIDTH  = DEFAULT_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEFAULT_IMAGE_HEIGHT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_r,
  input  logic [PIX_W-1:0] in_g,
  input  logic [PIX_W-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof,
  output logic             frame_done
);

  localparam int XW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int YW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);

  localparam logic [PROD_R_W-1:0]   COEF_R = PROD_R_W'(LUMA_COEF_R);
  localparam logic [PROD_G_W-1:0]   COEF_G = PROD_G_W'(LUMA_COEF_G);
  localparam logic [PROD_B_W-1:0]   COEF_B = PROD_B_W'(LUMA_COEF_B);
  localparam logic [LUMA_SUM_W-1:0] ROUND  = LUMA_SUM_W'(LUMA_ROUND);

  // Input position counters
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  // Stage 1: weighted products and markers
  logic                s1_valid_q, s1_valid_d;
  logic [PROD_R_W-1:0] s1_prod_r_q, s1_prod_r_d;
  logic [PROD_G_W-1:0] s1_prod_g_q, s1_prod_g_d;
  logic [PROD_B_W-1:0] s1_prod_b_q, s1_prod_b_d;
  marker_t             s1_mark_q, s1_mark_d;

  // Stage 2: luma output
  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_pixel_q, out_pixel_d;
  marker_t          out_mark_q, out_mark_d;
  logic             frame_done_q, frame_done_d;

  // Handshake / pipeline-advance controls
  logic                  adv2_s;
  logic                  in_hs_s;
  logic                  s1_to_s2_s;
  logic                  out_hs_s;
  marker_t               in_mark_s;
  logic [LUMA_SUM_W-1:0] luma_sum_s;
  logic [PIX_W-1:0]      luma_s;

  assign adv2_s     = !out_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || adv2_s;
  assign in_hs_s    = in_valid && in_ready;
  assign s1_to_s2_s = s1_valid_q && adv2_s;
  assign out_hs_s   = out_valid_q && out_ready;

  assign in_mark_s.sof = (x_q == '0) && (y_q == '0);
  assign in_mark_s.eol = (x_q == X_LAST);
  assign in_mark_s.eof = (x_q == X_LAST) && (y_q == Y_LAST);

  // Rounded luma: the 16-bit sum tops out at 65408, so the top byte is the result
  assign luma_sum_s = LUMA_SUM_W'(s1_prod_r_q) + s1_prod_g_q +
                      LUMA_SUM_W'(s1_prod_b_q) + ROUND;
  assign luma_s     = PIX_W'(luma_sum_s >> 8);

  // Raster counters advance only on accepted input pixels and wrap per frame
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (in_hs_s) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d = '0;
        end else begin
          y_d = y_q + YW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
      end
    end else begin
      x_d = x_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // Stage 1 next state: capture products on handshake, empty when drained
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_prod_r_d = s1_prod_r_q;
    s1_prod_g_d = s1_prod_g_q;
    s1_prod_b_d = s1_prod_b_q;
    s1_mark_d   = s1_mark_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (in_hs_s) begin
      s1_prod_r_d = PROD_R_W'(in_r) * COEF_R;
      s1_prod_g_d = PROD_G_W'(in_g) * COEF_G;
      s1_prod_b_d = PROD_B_W'(in_b) * COEF_B;
      s1_mark_d   = in_mark_s;
    end else begin
      s1_mark_d   = s1_mark_q;
    end
  end

  // Stage 1 registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_prod_r_q <= '0;
      s1_prod_g_q <= '0;
      s1_prod_b_q <= '0;
      s1_mark_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_prod_r_q <= s1_prod_r_d;
      s1_prod_g_q <= s1_prod_g_d;
      s1_prod_b_q <= s1_prod_b_d;
      s1_mark_q   <= s1_mark_d;
    end
  end

  // Stage 2 next state: output holds while stalled, frame_done follows the eof handshake
  always_comb begin
    out_valid_d  = out_valid_q;
    out_pixel_d  = out_pixel_q;
    out_mark_d   = out_mark_q;
    frame_done_d = out_hs_s && out_mark_q.eof;
    if (adv2_s) begin
      out_valid_d = s1_valid_q;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (s1_to_s2_s) begin
      out_pixel_d = luma_s;
      out_mark_d  = s1_mark_q;
    end else begin
      out_pixel_d = out_pixel_q;
    end
  end

  // Stage 2 registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_pixel_q  <= '0;
      out_mark_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_pixel_q  <= out_pixel_d;
      out_mark_q   <= out_mark_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_pixel  = out_pixel_q;
  assign out_sof    = out_mark_q.sof;
  assign out_eol    = out_mark_q.eol;
  assign out_eof    = out_mark_q.eof;
  assign frame_done = frame_done_q;

endmodule
